// File: rtl/ysyx_23060236_tlb_pkg.sv
// Shared widths and fill-target encoding for the MMU translation cache.
// The MMU port widths are taken from these constants so both sides stay in step.
package ysyx_23060236_tlb_pkg;

  localparam int TLB_ENTRIES = 8;
  localparam int VPN_W       = 20;
  localparam int PPN_W       = 20;

  // Which entry a fill lands in, highest priority first.
  typedef enum logic [1:0] {
    FILL_UPDATE  = 2'd0,
    FILL_INVALID = 2'd1,
    FILL_EVICT   = 2'd2
  } fill_sel_e;

endpackage

// File: rtl/ysyx_23060236_tlb_penc.sv
// Lowest-index priority encoder: returns the index of the lowest set bit and
// whether any bit is set. idx_o is 0 when nothing is set.
module ysyx_23060236_tlb_penc #(
  parameter  int N     = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scanning downwards lets the lowest set bit be the last one written.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060236_tlb.sv
// Fully associative VPN->PPN cache for the MMU: one-cycle registered lookup,
// fill with update/invalid/FIFO-victim priority, and a whole-table flush.
module ysyx_23060236_tlb
  import ysyx_23060236_tlb_pkg::*;
#(
  parameter  int ENTRIES = TLB_ENTRIES,
  parameter  int VPN_WD  = VPN_W,
  parameter  int PPN_WD  = PPN_W,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              tlb_rvalid,
  input  logic [VPN_WD-1:0] tlb_araddr,
  output logic              tlb_hit,
  output logic [PPN_WD-1:0] tlb_rdata,
  input  logic              tlb_wvalid,
  input  logic [VPN_WD-1:0] tlb_awaddr,
  input  logic [PPN_WD-1:0] tlb_wdata
);

  logic [VPN_WD-1:0]  tag_q [ENTRIES];
  logic [PPN_WD-1:0]  ppn_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               hit_q, hit_d;
  logic [PPN_WD-1:0]  rdata_q, rdata_d;

  logic [ENTRIES-1:0] rmatch, wmatch, invalid;
  logic [IDX_W-1:0]   r_idx, w_idx, inv_idx, fill_idx;
  logic               r_any, w_any, inv_any, fill_we;
  fill_sel_e          fill_sel;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      rmatch[i] = valid_q[i] && (tag_q[i] == tlb_araddr);
      wmatch[i] = valid_q[i] && (tag_q[i] == tlb_awaddr);
    end
    invalid = ~valid_q;
  end

  ysyx_23060236_tlb_penc #(.N(ENTRIES)) u_penc_lookup (
    .vec_i (rmatch),
    .idx_o (r_idx),
    .any_o (r_any)
  );

  ysyx_23060236_tlb_penc #(.N(ENTRIES)) u_penc_fill (
    .vec_i (wmatch),
    .idx_o (w_idx),
    .any_o (w_any)
  );

  ysyx_23060236_tlb_penc #(.N(ENTRIES)) u_penc_invalid (
    .vec_i (invalid),
    .idx_o (inv_idx),
    .any_o (inv_any)
  );

  // Flush dominates a same-edge fill; the lookup always sees pre-edge contents.
  always_comb begin
    fill_sel = FILL_EVICT;
    fill_idx = ptr_q;
    if (w_any) begin
      fill_sel = FILL_UPDATE;
      fill_idx = w_idx;
    end else if (inv_any) begin
      fill_sel = FILL_INVALID;
      fill_idx = inv_idx;
    end
    fill_we = tlb_wvalid && !flush;

    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (flush) begin
      valid_d = '0;
      ptr_d   = '0;
    end else if (fill_we) begin
      valid_d[fill_idx] = 1'b1;
      if (fill_sel == FILL_EVICT) begin
        ptr_d = ptr_q + IDX_W'(1);
      end
    end

    hit_d   = tlb_rvalid && r_any && !flush;
    rdata_d = (tlb_rvalid && r_any) ? ppn_q[r_idx] : rdata_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      ptr_q   <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
    end
  end

  // Tag/PPN storage carries no reset; valid_q alone qualifies it.
  always_ff @(posedge clock) begin
    if (fill_we) begin
      if (fill_sel != FILL_UPDATE) begin
        tag_q[fill_idx] <= tlb_awaddr;
      end
      ppn_q[fill_idx] <= tlb_wdata;
    end
  end

  assign tlb_hit   = hit_q;
  assign tlb_rdata = rdata_q;

endmodule

// File: tb/tb_ysyx_23060236_tlb.sv
// Directed and randomized checks of the TLB against a table-level reference model.
module tb_ysyx_23060236_tlb;

  localparam int N = 8;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        tlb_rvalid;
  logic [19:0] tlb_araddr;
  logic        tlb_hit;
  logic [19:0] tlb_rdata;
  logic        tlb_wvalid;
  logic [19:0] tlb_awaddr;
  logic [19:0] tlb_wdata;

  ysyx_23060236_tlb dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .tlb_rvalid (tlb_rvalid),
    .tlb_araddr (tlb_araddr),
    .tlb_hit    (tlb_hit),
    .tlb_rdata  (tlb_rdata),
    .tlb_wvalid (tlb_wvalid),
    .tlb_awaddr (tlb_awaddr),
    .tlb_wdata  (tlb_wdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  // Table of (vpn, ppn) slots; a slot is live when m_valid is set.
  bit          m_valid [N];
  logic [19:0] m_tag   [N];
  logic [19:0] m_ppn   [N];
  int          m_ptr;
  logic [19:0] m_rdata;

  logic [20:0] exp_q[$];
  int vectors;
  int miscompares;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_ptr   = 0;
    m_rdata = '0;
  endfunction

  function automatic int model_find(input logic [19:0] vpn);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_tag[i] == vpn) return i;
    return -1;
  endfunction

  function automatic void model_fill(input logic [19:0] vpn, input logic [19:0] ppn);
    int slot;
    slot = model_find(vpn);
    if (slot < 0) begin
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      if (slot < 0) begin
        slot  = m_ptr;
        m_ptr = (m_ptr + 1) % N;
      end
      m_tag[slot]   = vpn;
      m_valid[slot] = 1;
    end
    m_ppn[slot] = ppn;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed hit=%0b ppn=%05h expected hit=%0b ppn=%05h",
             tag, got[20], got[19:0], exp[20], exp[19:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, predicts the registered outputs, then samples #1 after the edge.
  task automatic step(input logic fl, input logic rv, input logic [19:0] ra,
                      input logic wv, input logic [19:0] wa, input logic [19:0] wd,
                      input string tag);
    int   hit_slot;
    logic e_hit;
    flush      = fl;
    tlb_rvalid = rv;
    tlb_araddr = ra;
    tlb_wvalid = wv;
    tlb_awaddr = wa;
    tlb_wdata  = wd;

    e_hit    = 1'b0;
    hit_slot = rv ? model_find(ra) : -1;
    if (hit_slot >= 0) begin
      m_rdata = m_ppn[hit_slot];
      e_hit   = !fl;
    end
    if (fl) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_ptr = 0;
    end else if (wv) begin
      model_fill(wa, wd);
    end
    exp_q.push_back({e_hit, m_rdata});

    @(posedge clock);
    #1;
    check(tag, {tlb_hit, tlb_rdata}, exp_q.pop_front());
  endtask

  task automatic lookup(input logic [19:0] vpn, input string tag);
    step(1'b0, 1'b1, vpn, 1'b0, 20'h0, 20'h0, tag);
  endtask

  task automatic fill(input logic [19:0] vpn, input logic [19:0] ppn, input string tag);
    step(1'b0, 1'b0, 20'h0, 1'b1, vpn, ppn, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 20'h0, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        fl, rv, wv;
    logic [19:0] ra, wa, wd;
    vectors     = 0;
    miscompares = 0;
    reset      = 1'b0;
    flush      = 1'b0;
    tlb_rvalid = 1'b0;
    tlb_araddr = '0;
    tlb_wvalid = 1'b0;
    tlb_awaddr = '0;
    tlb_wdata  = '0;
    model_reset();

    #12;
    check("reset_state", {tlb_hit, tlb_rdata}, 21'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    lookup(20'h12345, "cold_miss");
    fill(20'h12345, 20'h80001, "fill_first");
    lookup(20'h12345, "first_hit");
    idle("hit_pulse_drop");
    fill(20'h12345, 20'h80002, "refill_same_vpn");
    lookup(20'h12345, "refill_hit");

    // Nine distinct VPNs into eight slots: 0x0 is the FIFO victim.
    step(1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 20'h0, "flush_before_fifo");
    for (int v = 0; v <= N; v++) fill(20'(v), 20'h40000 + 20'(v), "fifo_fill");
    for (int v = 0; v <= N; v++) lookup(20'(v), $sformatf("fifo_lookup_%0d", v));
    fill(20'h00009, 20'h40009, "fifo_second_evict");
    lookup(20'h00001, "ptr_one_evicted");
    lookup(20'h00002, "ptr_two_kept");

    // A lookup in the same cycle as a fill sees the old mapping.
    step(1'b0, 1'b1, 20'h00002, 1'b1, 20'h00002, 20'h77777, "no_bypass");
    lookup(20'h00002, "after_write");

    step(1'b1, 1'b0, 20'h0, 1'b1, 20'h00abc, 20'h12121, "flush_with_fill");
    lookup(20'h00abc, "flushed_fill_miss");
    lookup(20'h00005, "flushed_old_miss");
    lookup(20'h00009, "flushed_recent_miss");

    // Random traffic over a small VPN pool so hits, updates and evictions all occur.
    for (int k = 0; k < 400; k++) begin
      fl = ($urandom_range(0, 39) == 0);
      rv = fl ? 1'b0 : 1'($urandom_range(0, 1));
      wv = 1'($urandom_range(0, 2) == 0);
      ra = 20'($urandom_range(0, 13));
      wa = 20'($urandom_range(0, 13));
      wd = 20'($urandom);
      step(fl, rv, ra, wv, wa, wd, "random");
    end

    // Reset landing while a hit is being presented.
    fill(20'h0beef, 20'h0cafe, "pre_reset_fill");
    lookup(20'h0beef, "pre_reset_hit");
    reset = 1'b0;
    #1;
    model_reset();
    check("async_reset_hit", {tlb_hit, tlb_rdata}, 21'h0);
    #3;
    reset = 1'b1;
    lookup(20'h0beef, "post_reset_miss");
    lookup(20'h00003, "post_reset_miss2");
    idle("post_reset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
